// File: rtl/mult_k_pkg.sv
// Shared definitions for the mult_k FP32 scale-by-K multiplier and its result queue.
// Latency constant must track the mult_k stage count.
package mult_k_pkg;
  localparam int MULT_K_LATENCY = 8;

  localparam int         EXP_MSB = 30;
  localparam int         EXP_LSB = 23;
  localparam int         MAN_MSB = 22;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } class_flags_t;

  // Denormals (exp==0, mantissa!=0) intentionally raise no flag.
  function automatic class_flags_t classify(input logic [31:0] p);
    class_flags_t f;
    logic [7:0]   e;
    logic         man_nz;
    e      = p[EXP_MSB:EXP_LSB];
    man_nz = |p[MAN_MSB:0];
    f.nan  = (e == EXP_MAX) &&  man_nz;
    f.inf  = (e == EXP_MAX) && !man_nz;
    f.zero = (e == 8'h00)   && !man_nz;
    return f;
  endfunction
endpackage

// File: rtl/mult_k_sync_fifo.sv
// Synchronous FIFO with flop storage and registered occupancy; head is read from storage,
// so a written entry becomes visible the cycle after the write (no bypass).
module mult_k_sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        full, wr_ok, rd_ok;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream credit gating must make this impossible.
  a_no_push_full: assert property (@(posedge clock) disable iff (!reset) !(wr_en && full));
endmodule

// File: rtl/mult_k_result_queue.sv
// Tracks operand issue through mult_k's fixed latency, captures FinalProduct with class flags,
// and presents results in issue order; issue is credit-gated so no result is dropped.
module mult_k_result_queue
  import mult_k_pkg::*;
#(
  parameter int LATENCY = MULT_K_LATENCY,
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [WIDTH-1:0]           product_in,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_data,
  output logic                       res_nan,
  output logic                       res_inf,
  output logic                       res_zero,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);
  localparam int CW = $clog2(DEPTH+1);

  logic [LATENCY-1:0] vld_pipe;
  logic [CW-1:0]      inflight;
  logic               op_fire, push, pop, empty;
  logic [CW:0]        fill_next, infl_next;
  class_flags_t       push_flags, head_flags;

  assign op_fire = op_valid && op_ready;
  assign push    = vld_pipe[LATENCY-1];
  assign pop     = res_valid && res_ready;

  assign push_flags = classify(product_in);

  mult_k_sync_fifo #(.WIDTH(WIDTH+3), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (push),
    .din   ({push_flags, product_in}),
    .rd_en (pop),
    .dout  ({head_flags, res_data}),
    .count (fill_level),
    .empty (empty)
  );

  assign res_valid = !empty;
  assign res_nan   = head_flags.nan;
  assign res_inf   = head_flags.inf;
  assign res_zero  = head_flags.zero;

  // Credits are computed from next-state occupancy, so op_ready is a plain flop with no
  // combinational path from res_ready; a pop frees its credit in the following cycle.
  always_comb begin
    fill_next = {1'b0, fill_level} + (CW+1)'(push) - (CW+1)'(pop);
    infl_next = {1'b0, inflight} + (CW+1)'(op_fire) - (CW+1)'(push);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      inflight <= '0;
      op_ready <= 1'b1;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-2:0], op_fire};
      inflight <= infl_next[CW-1:0];
      op_ready <= (fill_next + infl_next) < (CW+1)'(DEPTH);
    end
  end
endmodule

// File: tb/tb_mult_k_result_queue.sv
// Directed and randomized checks of mult_k_result_queue against a behavioural mult_k delay model.
module tb_mult_k_result_queue;
  localparam int LAT = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] product_in;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_nan, res_inf, res_zero;
  logic [3:0]  fill_level;

  logic [31:0] op_prod = 32'h0;
  logic [31:0] mk [LAT];
  int          tests = 0;
  int          fails = 0;

  mult_k_result_queue dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .product_in(product_in), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_nan(res_nan), .res_inf(res_inf), .res_zero(res_zero),
    .fill_level(fill_level)
  );

  always #5 clock = ~clock;

  // Stand-in for mult_k: the product of an accepted issue appears LAT edges later.
  always @(posedge clock) begin
    mk[0] <= (op_valid && op_ready) ? op_prod : 32'hDEADBEEF;
    for (int i = 1; i < LAT; i++) mk[i] <= mk[i-1];
  end
  assign product_in = mk[LAT-1];

  function automatic logic [2:0] exp_flags(input logic [31:0] p);
    logic [2:0] f;
    f = 3'b000;
    if (p[30:23] == 8'hFF) f = (p[22:0] != 0) ? 3'b100 : 3'b010;
    else if (p[30:0] == 31'h0) f = 3'b001;
    return f;
  endfunction

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic wait_fill(input int want, input string name);
    int n;
    n = 0;
    while (fill_level != 4'(want) && n < 30) begin step(); n++; end
    tests++;
    if (fill_level != 4'(want)) begin
      fails++; $display("FAIL %s_wait: fill_level %0d want %0d", name, fill_level, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; step(); step();
    tests++;
    if ({op_ready, res_valid, res_data, res_nan, res_inf, res_zero, fill_level} !==
        {1'b1, 1'b0, 32'h0, 3'b000, 4'd0}) begin
      fails++;
      $display("FAIL reset: rdy=%b vld=%b data=%h flags=%b%b%b fill=%0d want 1 0 0 000 0",
               op_ready, res_valid, res_data, res_nan, res_inf, res_zero, fill_level);
    end
    reset = 1'b1; step();
  endtask

  task automatic test_single();
    logic ok;
    op_valid = 1'b1; op_prod = 32'h40C00000;  // 2.0 * 3.0
    tests++;
    if (op_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", op_ready); end
    step(); op_valid = 1'b0;
    ok = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      if (res_valid !== 1'b0) ok = 1'b0;
      step();
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL single_early: res_valid before 9 cycles, want 0"); end
    tests++;
    if ({res_valid, res_data, res_nan, res_inf, res_zero} !== {1'b1, 32'h40C00000, 3'b000}) begin
      fails++;
      $display("FAIL single_result: vld=%b data=%h flags=%b%b%b want 1 40c00000 000",
               res_valid, res_data, res_nan, res_inf, res_zero);
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
    tests++;
    if ({res_valid, fill_level} !== {1'b0, 4'd0}) begin
      fails++; $display("FAIL single_pop: vld=%b fill=%0d want 0 0", res_valid, fill_level);
    end
  endtask

  task automatic issue8(input logic [31:0] base, input string name);
    for (int i = 0; i < 8; i++) begin
      op_valid = 1'b1; op_prod = base + 32'(i << 16);
      tests++;
      if (op_ready !== 1'b1) begin
        fails++; $display("FAIL %s_ready%0d: got %b want 1", name, i, op_ready);
      end
      step();
    end
    op_valid = 1'b0;
  endtask

  task automatic drain(input logic [31:0] base, input int n, input string name);
    res_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      tests++;
      if (res_valid !== 1'b1 || res_data !== base + 32'(i << 16)) begin
        fails++;
        $display("FAIL %s_drain%0d: vld=%b data=%h want 1 %h", name, i, res_valid, res_data,
                 base + 32'(i << 16));
      end
      step();
    end
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue8(32'h3F800000, "b2b");
    tests++;
    if (op_ready !== 1'b0) begin fails++; $display("FAIL b2b_credit: op_ready %b want 0", op_ready); end
    wait_fill(8, "b2b");
    drain(32'h3F800000, 8, "b2b");
    tests++;
    if ({fill_level, op_ready} !== {4'd0, 1'b1}) begin
      fails++; $display("FAIL b2b_empty: fill=%0d rdy=%b want 0 1", fill_level, op_ready);
    end
  endtask

  task automatic test_full_pop();
    logic ok;
    issue8(32'h41000000, "full");
    wait_fill(8, "full");
    op_valid = 1'b1; op_prod = 32'h42F60000;
    step(); step();
    tests++;
    if (op_ready !== 1'b0) begin fails++; $display("FAIL full_blocked: op_ready %b want 0", op_ready); end
    tests++;
    if (res_data !== 32'h41000000) begin
      fails++; $display("FAIL full_head: got %h want 41000000", res_data);
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
    tests++;
    if (op_ready !== 1'b1) begin fails++; $display("FAIL full_credit: op_ready %b want 1", op_ready); end
    step(); op_valid = 1'b0;
    tests++;
    if (op_ready !== 1'b0) begin fails++; $display("FAIL full_refill: op_ready %b want 0", op_ready); end
    ok = 1'b1;
    for (int j = 1; j < 8; j++) begin
      if (fill_level !== 4'd7) ok = 1'b0;
      step();
    end
    tests++;
    if (!ok || fill_level !== 4'd7) begin
      fails++; $display("FAIL full_early: fill=%0d want 7 until result lands", fill_level);
    end
    step();
    tests++;
    if (fill_level !== 4'd8) begin fails++; $display("FAIL full_land: fill=%0d want 8", fill_level); end
    res_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      tests++;
      if (res_data !== ((i == 8) ? 32'h42F60000 : 32'h41000000 + 32'(i << 16))) begin
        fails++; $display("FAIL full_drain%0d: got %h", i, res_data);
      end
      step();
    end
    res_ready = 1'b0;
  endtask

  task automatic test_flags();
    logic [31:0] pv [4];
    logic [2:0]  fv [4];
    pv[0] = 32'h7FC00000; fv[0] = 3'b100;
    pv[1] = 32'hFF800000; fv[1] = 3'b010;
    pv[2] = 32'h80000000; fv[2] = 3'b001;
    pv[3] = 32'h00000001; fv[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin op_valid = 1'b1; op_prod = pv[i]; step(); end
    op_valid = 1'b0;
    wait_fill(4, "flags");
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({res_data, res_nan, res_inf, res_zero} !== {pv[i], fv[i]}) begin
        fails++;
        $display("FAIL flags%0d: data=%h flags=%b%b%b want %h %b", i, res_data,
                 res_nan, res_inf, res_zero, pv[i], fv[i]);
      end
      step();
    end
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ok;
    for (int i = 0; i < 3; i++) begin op_valid = 1'b1; op_prod = 32'h3F000000; step(); end
    op_valid = 1'b0;
    step();
    reset = 1'b0; #1;
    tests++;
    if ({op_ready, res_valid, fill_level} !== {1'b1, 1'b0, 4'd0}) begin
      fails++; $display("FAIL rstmid_async: rdy=%b vld=%b fill=%0d want 1 0 0",
                        op_ready, res_valid, fill_level);
    end
    step(); step();
    reset = 1'b1;
    ok = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (res_valid !== 1'b0 || fill_level !== 4'd0 || op_ready !== 1'b1) ok = 1'b0;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL rstmid_stale: stale result or lost credit after reset"); end
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic [31:0] exp_v;
    logic [31:0] specials [4];
    int fired, popped, cyc;
    specials[0] = 32'h7F800001; specials[1] = 32'h7F800000;
    specials[2] = 32'h00000000; specials[3] = 32'h00400000;
    fired = 0; popped = 0; cyc = 0;
    while (popped < 200 && cyc < 5000) begin
      op_valid  = (fired < 200) && ($urandom_range(0, 1) == 1);
      op_prod   = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      res_ready = ($urandom_range(0, 1) == 1);
      if (fill_level > 4'd8) begin
        tests++; fails++; $display("FAIL rand_overfill: fill=%0d want <=8", fill_level);
      end
      if (res_valid && res_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rand_spurious: data=%h want no result", res_data);
        end else begin
          exp_v = q.pop_front();
          if ({res_data, res_nan, res_inf, res_zero} !== {exp_v, exp_flags(exp_v)}) begin
            fails++;
            $display("FAIL rand_pop%0d: data=%h flags=%b%b%b want %h %b", popped, res_data,
                     res_nan, res_inf, res_zero, exp_v, exp_flags(exp_v));
          end
        end
        popped++;
      end
      if (op_valid && op_ready) begin q.push_back(op_prod); fired++; end
      step();
      cyc++;
    end
    op_valid = 1'b0; res_ready = 1'b0;
    tests++;
    if (popped != 200 || fired != 200) begin
      fails++; $display("FAIL rand_count: fired=%0d popped=%0d want 200 200", fired, popped);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_flags();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
